// File: rtl/zjh_scan_disp.sv
// Multiplexed 7-segment scan driver.
// A prescaler produces one digit slot every DIV cycles, and the slot index
// walks through NDIG digits. The index wrapping back to 0 is a "frame"
// boundary, and new digit data is only adopted there, so a frame never
// shows a mix of old and new digits. All display outputs are registered.

// Per-digit lane: BCD-to-7-segment decode, with leading-zero blanking applied.
module zjh_scan_lane (
  input  logic [3:0] dig_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  // Segment order is abcdefg, with a in bit 6; codes 10..15 stay dark.
  always_comb begin
    seg_o = 7'b0000000;
    if (!blank_i) begin
      case (dig_i)
        4'd0:    seg_o = 7'b1111110;
        4'd1:    seg_o = 7'b0110000;
        4'd2:    seg_o = 7'b1101101;
        4'd3:    seg_o = 7'b1111001;
        4'd4:    seg_o = 7'b0110011;
        4'd5:    seg_o = 7'b1011011;
        4'd6:    seg_o = 7'b0011111;
        4'd7:    seg_o = 7'b1110000;
        4'd8:    seg_o = 7'b1111111;
        4'd9:    seg_o = 7'b1110011;
        default: seg_o = 7'b0000000;
      endcase
    end
  end
endmodule

module zjh_scan_disp #(
  parameter int NDIG      = 4,
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 1
) (
  input  logic              Clock,
  input  logic              Aclr,
  input  logic              En,
  input  logic              Load,
  input  logic [4*NDIG-1:0] Din,
  input  logic [NDIG-1:0]   DpIn,
  input  logic              Lzb,
  output logic [NDIG-1:0]   Y,
  output logic [6:0]        Seg,
  output logic              Dp,
  output logic              Frame
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] act_dig_q, act_dig_d, shd_dig_q, shd_dig_d;
  logic [NDIG-1:0]   act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
  logic              pend_q, pend_d;
  logic [NDIG-1:0]   y_q, y_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d, frame_q, frame_d;

  logic tick, last, wrap;

  assign tick = En && (cnt_q == CW'(DIV - 1));
  assign last = (idx_q == IW'(NDIG - 1));
  assign wrap = tick && last;

  // Prescaler and digit index advance; both freeze while En is low.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (En) begin
      if (tick) begin
        cnt_d = '0;
        idx_d = last ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Shadow/active double buffer. A Load in the wrap cycle bypasses the shadow
  // so the newest data wins. The pending flag drops at every wrap.
  always_comb begin
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    pend_d    = pend_q;
    if (Load) begin
      shd_dig_d = Din;
      shd_dp_d  = DpIn;
    end
    if (wrap) begin
      pend_d = 1'b0;
      if (Load) begin
        act_dig_d = Din;
        act_dp_d  = DpIn;
      end else if (pend_q) begin
        act_dig_d = shd_dig_q;
        act_dp_d  = shd_dp_q;
      end
    end else if (Load) begin
      pend_d = 1'b1;
    end
  end

  // Leading-zero chain: lead[k] is set when digits NDIG-1..k are all zero.
  logic [NDIG-1:0]      lead, lane_blank;
  logic [NDIG-1:0][6:0] lane_seg;

  genvar k;
  generate
    for (k = 0; k < NDIG; k++) begin : g_lane
      if (k == NDIG - 1) begin : g_top
        assign lead[k] = (act_dig_q[4*k +: 4] == 4'd0);
      end else begin : g_mid
        assign lead[k] = (act_dig_q[4*k +: 4] == 4'd0) && lead[k+1];
      end
      if (k == 0) begin : g_d0
        assign lane_blank[k] = 1'b0;
      end else begin : g_dn
        assign lane_blank[k] = Lzb && lead[k];
      end
      zjh_scan_lane u_lane (
        .dig_i   (act_dig_q[4*k +: 4]),
        .blank_i (lane_blank[k]),
        .seg_o   (lane_seg[k])
      );
    end
  endgenerate

  // Output stage: the next registered outputs are computed from this cycle's
  // index and prescaler. The display stays dark during the anti-ghost window
  // and while scanning is disabled.
  always_comb begin
    y_d     = '1;
    seg_d   = 7'b0000000;
    dp_d    = 1'b0;
    frame_d = wrap;
    if (En && (int'(cnt_q) >= BLANK_CYC)) begin
      y_d[idx_q] = 1'b0;
      seg_d      = lane_seg[idx_q];
      dp_d       = act_dp_q[idx_q];
    end
  end

  // State and output registers; asynchronous clear blanks the display.
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      pend_q    <= 1'b0;
      y_q       <= '1;
      seg_q     <= 7'b0000000;
      dp_q      <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      pend_q    <= pend_d;
      y_q       <= y_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign Y     = y_q;
  assign Seg   = seg_q;
  assign Dp    = dp_q;
  assign Frame = frame_q;
endmodule

// File: doc/zjh_scan_disp.md
ZJH_SCAN_DISP -- requirements
Module: zjh_scan_disp

Interface
REQ-001 Parameter NDIG, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV, default 1000, Clock cycles per digit slot, legal range 2..65535.
REQ-003 Parameter BLANK_CYC, default 1, anti-ghost blank cycles at the start of each slot, legal range 0..DIV-1.
REQ-004 Port Clock, input, 1, sole clock, rising edge.
REQ-005 Port Aclr, input, 1, reset, asynchronous, active-low.
REQ-006 Port En, input, 1, scan enable.
REQ-007 Port Load, input, 1, one-cycle strobe that captures Din and DpIn.
REQ-008 Port Din, input, 4*NDIG, BCD digits; nibble k is digit k, digit 0 least significant.
REQ-009 Port DpIn, input, NDIG, decimal point per digit.
REQ-010 Port Lzb, input, 1, leading-zero blanking enable.
REQ-011 Port Y, output, NDIG, digit enables, active-low, one-hot-low while lit.
REQ-012 Port Seg, output, 7, segments active-high; Seg[6]=a ... Seg[0]=g.
REQ-013 Port Dp, output, 1, decimal point, active-high.
REQ-014 Port Frame, output, 1, one-cycle pulse on each scan wrap.

Function
REQ-015 Prescaler counts 0..DIV-1 while En=1; tick = (count==DIV-1); it wraps to 0 on tick.
REQ-016 Digit index advances by 1 on tick, wrapping from NDIG-1 to 0; wrap asserts Frame in the following cycle.
REQ-017 En=0 holds prescaler and index, forces Y all ones, Seg=0, Dp=0, Frame=0; En=1 resumes from the held state.
REQ-018 Load writes a shadow register (digits + Dp) and sets pending; a second Load before wrap overwrites the shadow, so the last Load wins.
REQ-019 On wrap, the active register takes Din/DpIn if Load is asserted in that same cycle, else the shadow if pending, else it holds; pending clears on wrap.
REQ-020 Displayed data changes only at wrap; no frame shows a mix of old and new digits.
REQ-021 Outputs are registered; Y/Seg/Dp reflect the index and prescaler state of the previous cycle (1-cycle latency).
REQ-022 Blank window: while prescaler count < BLANK_CYC, Y is all ones, Seg=0, Dp=0.
REQ-023 Outside the blank window, Y[index]=0, all other Y bits=1, Seg=decode(active digit index), and Dp=active Dp[index].
REQ-024 Decode, abcdefg order:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1110011
- codes 10..15 give 0000000.
REQ-025 With Lzb=1, digit k>0 shows Seg=0 when digits NDIG-1..k are all zero; digit 0 is never blanked; Dp is unaffected; Y still selects the digit.

Reset
REQ-026 Aclr=0 immediately sets the following to zero: prescaler, index, active, shadow and pending.
REQ-027 Aclr=0 immediately sets Y all ones, Seg=0, Dp=0, Frame=0.
REQ-028 Reset mid-slot or mid-Load discards the pending data.
REQ-029 After reset release, the first tick occurs DIV cycles after the first Clock edge with Aclr=1 and En=1.

Verification (NDIG=4, DIV=4, BLANK_CYC=1)
REQ-030 Reset with Aclr=0 held mid-scan -> Y=1111, Seg=0000000, Dp=0, Frame=0 asynchronously, before any Clock edge.
REQ-031 Load Din=0x4321, En=1, Lzb=0 -> after the next wrap, each 4-cycle slot has 1 blank cycle then Y=1110/Seg=0110000, 1101/1101101, 1011/1111001, 0111/0110011; Frame pulses every 16 cycles.
REQ-032 Active Din=0x0070, Lzb=1 -> digits 3 and 2 have Seg=0 while Y still selects them; digit 1 shows 1110000 and digit 0 shows 1111110. Din=0x0000 -> only digit 0 shows 1111110.
REQ-033 Load 0x1111 then 0x2222 in one frame, then Load 0x3333 in the wrap cycle -> the next frame shows 3333, never 1111 or a mix.
REQ-034 En=0 for 10 cycles mid-slot -> Y=1111 throughout; on En=1 the scan resumes at the same index and prescaler count. Din nibble 0xC -> Seg=0000000 for that digit.
